// File: rtl/data_memory_dumper.sv
// rtl/data_memory_dumper.sv - walks the data memory and streams every word out LSB byte first
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends a modulo-256 sum byte after the data.
module data_memory_dumper #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_ADDRESS   = 64,
  parameter int NB_ADDRESS  = $clog2(N_ADDRESS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  output logic [NB_ADDRESS-1:0]  o_r_addr,
  output logic                   o_r_en,
  output logic [1:0]             o_r_addressing,
  output logic                   o_r_signing,
  input  logic [NB_DATA_BUS-1:0] i_r_data,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NB_WCNT = NB_ADDRESS - 2;
  localparam logic [NB_WCNT-1:0] LAST_WORD = NB_WCNT'(N_ADDRESS / 4 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
`ifdef MEM_DUMP_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [NB_WCNT-1:0]     word_cnt_q;
  logic [1:0]             byte_idx_q;
  logic [NB_DATA_BUS-1:0] shift_q;
  logic                   busy_q;
  logic                   hs;
  logic [NB_BYTE-1:0]     tx_data;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]     csum_q;
`endif

  // Word access, never sign extended.
  assign o_r_addressing = 2'b11;
  assign o_r_signing    = 1'b0;
  assign o_r_en         = (state_q == S_READ);
  assign o_r_addr       = {word_cnt_q, 2'b00};
  assign o_busy         = busy_q;
  assign o_done         = (state_q == S_DONE);
`ifdef MEM_DUMP_CHECKSUM_EN
  assign o_tx_valid     = (state_q == S_SEND) || (state_q == S_CSUM);
`else
  assign o_tx_valid     = (state_q == S_SEND);
`endif
  assign hs             = o_tx_valid & i_tx_ready;
  assign o_tx_data      = tx_data;

  // Stream byte mux: data byte while sending, sum byte in CSUM, zero otherwise.
  always_comb begin
    tx_data = '0;
    if (state_q == S_SEND) tx_data = shift_q[NB_BYTE-1:0];
`ifdef MEM_DUMP_CHECKSUM_EN
    if (state_q == S_CSUM) tx_data = csum_q;
`endif
  end

  // Next-state logic; the last-word compare keeps the counter from wrapping to address 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) state_d = S_READ;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
      S_SEND: begin
        if (hs && (byte_idx_q == 2'd3)) begin
          if (word_cnt_q < LAST_WORD) begin
            state_d = S_READ;
          end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM:  if (hs) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and datapath; reset mid-dump drops any pending byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            word_cnt_q <= '0;
            byte_idx_q <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_LATCH: begin
          shift_q    <= i_r_data;
          byte_idx_q <= '0;
        end
        S_SEND: begin
          if (hs) begin
            shift_q    <= shift_q >> NB_BYTE;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q     <= csum_q + shift_q[NB_BYTE-1:0];
`endif
            if ((byte_idx_q == 2'd3) && (word_cnt_q < LAST_WORD)) begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_dumper.sv
// tb/tb_data_memory_dumper.sv - scoreboard bench for data_memory_dumper
module tb_data_memory_dumper;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [5:0]  o_r_addr;
  logic        o_r_en;
  logic [1:0]  o_r_addressing;
  logic        o_r_signing;
  logic [31:0] i_r_data = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_busy;
  logic        o_done;

  data_memory_dumper dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .o_r_addr(o_r_addr), .o_r_en(o_r_en), .o_r_addressing(o_r_addressing),
    .o_r_signing(o_r_signing), .i_r_data(i_r_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int N_STREAM = 65;
`else
  localparam int N_STREAM = 64;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [16];
  logic [7:0]  sb_q [$];
  int          addr_q [$];
  int          hs_total = 0;
  int          ren_total = 0;
  logic        v_s, done_s, busy_s, ren_s, rdy_s;
  logic [7:0]  d_s;
  logic [5:0]  addr_s;
  logic        stall_q = 1'b0;
  logic [7:0]  stall_d = '0;
  logic        prev_ren = 1'b0;

  // One clock: sample mid-cycle, score handshakes and reads, then return just after the edge.
  task automatic tick();
    logic [7:0] e;
    int ea;
    @(negedge i_clk);
    v_s = o_tx_valid; d_s = o_tx_data; done_s = o_done; busy_s = o_busy;
    ren_s = o_r_en; addr_s = o_r_addr; rdy_s = i_tx_ready;
    if (i_rst_n) begin
      if (stall_q) begin
        checks++;
        if (!(v_s === 1'b1 && d_s === stall_d)) begin
          failures++;
          $display("FAIL hold: valid=%b data=%02h required valid=1 data=%02h", v_s, d_s, stall_d);
        end
      end
      if (v_s && rdy_s) begin
        hs_total++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got byte %02h, none expected", d_s);
        end else begin
          e = sb_q.pop_front();
          if (d_s !== e) begin
            failures++;
            $display("FAIL stream_byte: got %02h required %02h", d_s, e);
          end
        end
      end
      if (ren_s) begin
        ren_total++;
        checks++;
        if (prev_ren) begin
          failures++;
          $display("FAIL r_en_consecutive: r_en=1 two cycles in a row, required isolated");
        end
        checks++;
        if (addr_q.size() == 0) begin
          failures++;
          $display("FAIL r_addr_extra: got read at %0d, none expected", addr_s);
        end else begin
          ea = addr_q.pop_front();
          if (int'(addr_s) !== ea) begin
            failures++;
            $display("FAIL r_addr: got %0d required %0d", addr_s, ea);
          end
        end
      end
      checks++;
      if (o_r_addressing !== 2'b11 || o_r_signing !== 1'b0) begin
        failures++;
        $display("FAIL const_ports: addressing=%b signing=%b required 11/0", o_r_addressing, o_r_signing);
      end
      stall_q = v_s && !rdy_s;
      stall_d = d_s;
      prev_ren = ren_s;
    end else begin
      stall_q = 1'b0;
      prev_ren = 1'b0;
    end
    @(posedge i_clk);
    #1;
    if (ren_s) i_r_data = mem[addr_s[5:2]];
  endtask

  // Push the expected stream for the current memory, pulse start, and run until done (bounded).
  task automatic run_dump(input bit rnd, input int pa, input int pb,
                          output int fv, output int dc, output int dn,
                          output int busy_after, output int nren, output int nhs);
    int ren0, hs0;
    logic [7:0] sum, b;
    sum = '0;
    for (int k = 0; k < 16; k++) begin
      addr_q.push_back(k * 4);
      for (int j = 0; j < 4; j++) begin
        b = mem[k][j*8 +: 8];
        sb_q.push_back(b);
        sum = sum + b;
      end
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    sb_q.push_back(sum);
`endif
    ren0 = ren_total; hs0 = hs_total;
    fv = 0; dc = 0; dn = 0; busy_after = -1;
    i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (rnd) i_tx_ready = 1'($urandom_range(0, 1));
      i_start = (c == pa) || (c == pb);
      tick();
      if (v_s && fv == 0) fv = c;
      if (done_s) begin
        dn++;
        if (dc == 0) dc = c;
      end
      if (dc != 0 && c == dc + 1) busy_after = int'(busy_s);
      if (dc != 0 && c >= dc + 20) break;
    end
    i_start = 1'b0;
    i_tx_ready = 1'b1;
    nren = ren_total - ren0;
    nhs = hs_total - hs0;
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 16; k++) mem[k] = 32'h0403_0201 + k * 32'h0404_0404;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (v_s !== 1'b0 || d_s !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx: valid=%b data=%02h required 0/00", v_s, d_s);
    end
    checks++;
    if (ren_s !== 1'b0 || addr_s !== 6'd0) begin
      failures++;
      $display("FAIL reset_rd: r_en=%b addr=%0d required 0/0", ren_s, addr_s);
    end
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b required 0/0", busy_s, done_s);
    end
  endtask

  task automatic test_ready_high();
    int fv, dc, dn, ba, nren, nhs;
    load_pattern();
    run_dump(1'b0, 0, 0, fv, dc, dn, ba, nren, nhs);
    checks++;
    if (fv != 3) begin failures++; $display("FAIL first_valid: cycle %0d required 3", fv); end
    checks++;
    if (dc != 97) begin failures++; $display("FAIL done_cycle: cycle %0d required 97", dc); end
    checks++;
    if (nren != 16) begin failures++; $display("FAIL r_en_count: %0d required 16", nren); end
    checks++;
    if (nhs != N_STREAM) begin failures++; $display("FAIL byte_count: %0d required %0d", nhs, N_STREAM); end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_left: %0d bytes left required 0", sb_q.size()); end
  endtask

  task automatic test_start_ignored();
    int fv, dc, dn, ba, nren, nhs;
    load_pattern();
    run_dump(1'b0, 10, 97, fv, dc, dn, ba, nren, nhs);
    checks++;
    if (dn != 1) begin failures++; $display("FAIL done_pulses: %0d required 1", dn); end
    checks++;
    if (ba != 0) begin failures++; $display("FAIL busy_after_done: %0d required 0", ba); end
    checks++;
    if (nhs != N_STREAM) begin failures++; $display("FAIL ignored_bytes: %0d required %0d", nhs, N_STREAM); end
    checks++;
    if (nren != 16) begin failures++; $display("FAIL ignored_reads: %0d required 16", nren); end
  endtask

  task automatic test_stall();
    int fv, dc, dn, ba, nren, nhs;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    run_dump(1'b1, 0, 0, fv, dc, dn, ba, nren, nhs);
    checks++;
    if (dn != 1) begin failures++; $display("FAIL stall_done: %0d pulses required 1", dn); end
    checks++;
    if (nhs != N_STREAM) begin failures++; $display("FAIL stall_bytes: %0d required %0d", nhs, N_STREAM); end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL stall_sb_left: %0d required 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    int fv, dc, dn, ba, nren, nhs, hs0;
    load_pattern();
    for (int k = 0; k < 16; k++) addr_q.push_back(k * 4);
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 4; j++) sb_q.push_back(mem[k][j*8 +: 8]);
    hs0 = hs_total;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 500 && (hs_total - hs0) < 22; c++) tick();
    checks++;
    if (hs_total - hs0 != 22) begin
      failures++;
      $display("FAIL mid_reach: %0d bytes required 22", hs_total - hs0);
    end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (v_s !== 1'b0 || d_s !== 8'h00 || ren_s !== 1'b0 || addr_s !== 6'd0 ||
        busy_s !== 1'b0 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: valid=%b data=%02h r_en=%b addr=%0d busy=%b done=%b required all 0",
               v_s, d_s, ren_s, addr_s, busy_s, done_s);
    end
    sb_q.delete();
    addr_q.delete();
    run_dump(1'b0, 0, 0, fv, dc, dn, ba, nren, nhs);
    checks++;
    if (dc != 97 || nhs != N_STREAM) begin
      failures++;
      $display("FAIL restart_dump: done=%0d bytes=%0d required 97/%0d", dc, nhs, N_STREAM);
    end
  endtask

`ifdef MEM_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int fv, dc, dn, ba, nren, nhs;
    for (int k = 0; k < 16; k++) mem[k] = 32'hFFFF_FFFF;
    run_dump(1'b0, 0, 0, fv, dc, dn, ba, nren, nhs);
    checks++;
    if (nhs != 65 || dn != 1) begin
      failures++;
      $display("FAIL checksum_stream: bytes=%0d done=%0d required 65/1", nhs, dn);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ready_high();
    test_start_ignored();
    test_stall();
    test_reset_mid();
`ifdef MEM_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_dumper.md
# data_memory_dumper

Read-side debug engine for the data memory. On a start pulse it walks every word of the data memory with aligned word reads, unsigned and non-extending. It serialises each 32-bit word into bytes, least significant byte first, over a valid/ready byte stream that feeds the debug UART transmitter. It sits between the debug unit and the data-memory read port, which it owns while busy, so the dump reflects memory contents after a halted program.

## Interface
- NB_DATA_BUS, 32, memory word width; fixed at 32, four bytes per word.
- NB_BYTE, 8, stream byte width.
- N_ADDRESS, 64, memory size in bytes; must be a multiple of 4; N_ADDRESS/4 words are dumped.
- NB_ADDRESS, $clog2(N_ADDRESS), byte-address width.
- i_clk  in  1  single clock, all logic on posedge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- o_r_addr  out  NB_ADDRESS  byte address to memory; always word aligned, [1:0]=2'b00.
- o_r_en  out  1  memory read enable.
- o_r_addressing  out  2  constant 2'b11 (word access).
- o_r_signing  out  1  constant 0.
- i_r_data  in  NB_DATA_BUS  memory read data; valid the cycle after o_r_en.
- o_tx_data  out  NB_BYTE  stream byte.
- o_tx_valid  out  1  stream byte valid.
- i_tx_ready  in  1  transmitter accepts the byte when o_tx_valid & i_tx_ready.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, READ, LATCH, SEND, (CSUM), DONE.
- IDLE: waits for i_start. On i_start it clears the word counter, byte index and checksum, then goes to READ.
- READ: drives o_r_en=1 and o_r_addr={word_cnt,2'b00} for exactly one cycle, then goes to LATCH.
- LATCH: registers i_r_data into the 32-bit shift register, byte index=0, then goes to SEND.
- SEND: o_tx_valid=1 and o_tx_data=shift[7:0]. On handshake the register shifts right by 8, the byte index increments and the byte is added to the checksum. After the handshake on byte index 3:
  - if word_cnt < N_ADDRESS/4-1, word_cnt increments and the FSM goes to READ;
  - otherwise it goes to CSUM (macro defined) or DONE.
- With no handshake, o_tx_data and o_tx_valid hold stable; valid never drops before acceptance.
- DONE: o_done=1 for one cycle, then IDLE.
- o_r_en is 0 outside READ. o_r_addr holds its last value.
- Word counter width is NB_ADDRESS-2. The last-word compare prevents wrap; address 0 is never re-read within one dump.
- i_start outside IDLE (including the DONE cycle) is ignored, not queued.

## Timing
- Reset values: o_tx_valid=0, o_tx_data=0, o_r_en=0, o_r_addr=0, o_busy=0, o_done=0. State is IDLE, and the counters, shift register and checksum are 0.
- Reset applied mid-dump aborts on the next edge. Outputs take their reset values, and any pending stream byte is dropped. A later start restarts at address 0.
- i_start sampled high at edge 0 puts READ in cycle 1, LATCH in cycle 2, and the first o_tx_valid in cycle 3.
- With i_tx_ready held high, each word takes 6 cycles (READ, LATCH, 4×SEND).
- Without checksum, a full default dump of 16 words is 96 busy cycles plus one DONE cycle.
- Each stalled ready cycle adds exactly one cycle.
- o_busy is registered from state and rises the cycle after the start is sampled.

## Configuration
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined: after the last data byte the FSM enters CSUM. CSUM drives o_tx_valid=1 with o_tx_data equal to the 8-bit modulo-256 sum of all data bytes sent in this dump, under the same handshake rules, then goes to DONE. The stream has N_ADDRESS+1 bytes.
- Undefined: no CSUM state and no checksum register; the stream has exactly N_ADDRESS bytes.

## Test plan
- Memory word k = 32'h0403_0201 + k*32'h0404_0404, ready always high, start pulse:
  - bytes 01,02,03,04,05,06,07,08,… in order;
  - o_r_addr sequence 0,4,8,…,60;
  - first valid at cycle 3; o_done at cycle 97.
- Random i_tx_ready stalls (≈50%): the byte sequence is identical to the stall-free run, o_tx_data is stable whenever valid=1 and ready=0, and there are no duplicate or dropped bytes.
- i_start pulsed again at cycles 10 and 97 (the DONE cycle): ignored. Exactly one dump of 64 bytes occurs, and o_busy=0 at cycle 98.
- i_rst_n=0 for one cycle during byte 2 of word 5: all outputs are 0 the next cycle. A new start produces a full dump beginning at byte 01 and address 0.
- With MEM_DUMP_CHECKSUM_EN and all words = 32'hFFFF_FFFF: 64 bytes of FF, then checksum byte 8'hC0 (64×255 mod 256), then o_done.
- With o_r_en observed: it is high exactly 16 cycles per dump, never in two consecutive cycles. o_r_addressing=2'b11 and o_r_signing=0 throughout.
